// File: rtl/vec_mem_responder_if.sv
// Request/response bundle between the memory stage and vec_mem_responder.
// The master side is the requester; the slave side is the responder.
// Optional VMEM_STRIDE_EN adds the req_stride field.
interface vec_mem_responder_if #(
    parameter int ELEM_W = 16,
    parameter int LANES  = 16
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic                      req_vec;
    logic [31:0]               req_addr;
    logic [ELEM_W-1:0]         req_wdata;
    logic [LANES*ELEM_W-1:0]   req_vwdata;
`ifdef VMEM_STRIDE_EN
    logic [15:0]               req_stride;
`endif
    logic                      rsp_valid;
    logic [31:0]               rdata;
    logic [LANES*ELEM_W-1:0]   vrdata;
    logic                      busy;

`ifdef VMEM_STRIDE_EN
    modport master (
        output req_valid, req_we, req_vec, req_addr, req_wdata, req_vwdata, req_stride,
        input  req_ready, rsp_valid, rdata, vrdata, busy
    );
    modport slave (
        input  req_valid, req_we, req_vec, req_addr, req_wdata, req_vwdata, req_stride,
        output req_ready, rsp_valid, rdata, vrdata, busy
    );
`else
    modport master (
        output req_valid, req_we, req_vec, req_addr, req_wdata, req_vwdata,
        input  req_ready, rsp_valid, rdata, vrdata, busy
    );
    modport slave (
        input  req_valid, req_we, req_vec, req_addr, req_wdata, req_vwdata,
        output req_ready, rsp_valid, rdata, vrdata, busy
    );
`endif
endinterface

// File: rtl/vec_mem_responder.sv
// Memory-side responder: serves scalar and vector loads/stores from a
// single-port 16-bit synchronous RAM, one element beat per cycle.
// Optional feature macro: VMEM_STRIDE_EN (adds a per-request lane stride).
module vec_mem_responder #(
    parameter int DEPTH  = 4096,
    parameter int ELEM_W = 16,
    parameter int LANES  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    vec_mem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(LANES);
    localparam int VW = LANES * ELEM_W;

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

    state_t              state_q;
    logic [BW-1:0]       beat_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rd_pend_q;
    logic [BW-1:0]       rd_lane_q;

    logic                we_q;
    logic                vec_q;
    logic [AW-1:0]       base_q;
    logic [VW-1:0]       wdata_q;
`ifdef VMEM_STRIDE_EN
    logic [AW-1:0]       stride_q;
`endif

    logic [ELEM_W-1:0]   ram_rdata_q;
    logic [31:0]         rdata_q;
    logic [VW-1:0]       vrdata_q;
    logic [ELEM_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                last_beat;
    logic                ram_we;
    logic                ram_re;
    logic [AW-1:0]       addr_d;
    logic [ELEM_W-1:0]   ram_wdata;

    // Address bits above the RAM index range (and stride bits above it) never matter modulo DEPTH.
    logic unused_bits;
`ifdef VMEM_STRIDE_EN
    assign unused_bits = ^{bus.req_addr[31:AW], bus.req_stride[15:AW]};
`else
    assign unused_bits = ^bus.req_addr[31:AW];
`endif

    assign accept = bus.req_valid && req_ready_q;

    // Beat address, write lane and RAM enables; writes are blocked while reset is asserted so an aborted beat leaves RAM untouched.
    always_comb begin
`ifdef VMEM_STRIDE_EN
        addr_d    = base_q + (AW'(beat_q) * stride_q);
`else
        addr_d    = base_q + AW'(beat_q);
`endif
        last_beat = vec_q ? (beat_q == BW'(LANES - 1)) : 1'b1;
        ram_we    = (state_q == ACCESS) && we_q && reset;
        ram_re    = (state_q == ACCESS) && !we_q;
        ram_wdata = wdata_q[beat_q*ELEM_W +: ELEM_W];
    end

    // Single-port RAM: one write or one registered read per cycle.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[addr_d] <= ram_wdata;
        end else if (ram_re) begin
            ram_rdata_q <= mem[addr_d];
        end
    end

    // Request capture; held stable for the whole operation since accept only happens in IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            vec_q   <= bus.req_vec;
            base_q  <= bus.req_addr[AW-1:0];
            wdata_q <= bus.req_vec ? bus.req_vwdata : {{(VW-ELEM_W){1'b0}}, bus.req_wdata};
`ifdef VMEM_STRIDE_EN
            stride_q <= bus.req_stride[AW-1:0];
`endif
        end
        rd_lane_q <= beat_q;
    end

    // Control FSM with registered handshake outputs; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= ACCESS;
                        beat_q      <= '0;
                        req_ready_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    rd_pend_q <= !we_q;
                    if (last_beat) begin
                        beat_q      <= '0;
                        state_q     <= we_q ? RESP : DRAIN;
                        rsp_valid_q <= we_q;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DRAIN: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Load data lands one cycle after its read was issued, in the lane of the issuing beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q  <= '0;
            vrdata_q <= '0;
        end else if (rd_pend_q) begin
            if (vec_q) begin
                vrdata_q[rd_lane_q*ELEM_W +: ELEM_W] <= ram_rdata_q;
            end else begin
                rdata_q <= {{(32-ELEM_W){1'b0}}, ram_rdata_q};
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = ~req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.vrdata    = vrdata_q;

endmodule
